// File: rtl/uart_deframe_fifo.sv
// rtl/uart_deframe_fifo.sv - UART frame checker feeding a show-ahead payload FIFO
// Frames are checked on arrival; payload plus parity/framing flags are queued for the consumer.
module uart_deframe_fifo #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  localparam int FRAME_W   = 1 + DATA_W + PARITY_EN + STOP_BITS,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  input  logic               clr_err,
  output logic [DATA_W-1:0]  data_out,
  output logic               parity_err,
  output logic               frame_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CW-1:0]      fifo_count,
  output logic               overflow,
  output logic [15:0]        err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 2;

  logic [DATA_W-1:0]    payload;
  logic [STOP_BITS-1:0] stop_bits;
  logic                 perr;
  logic                 ferr;

  assign payload   = frame_in[DATA_W:1];
  assign stop_bits = frame_in[FRAME_W-1 -: STOP_BITS];
  assign ferr      = frame_in[0] | ~(&stop_bits);

  generate
    if (PARITY_EN != 0) begin : g_parity
      assign perr = ((^{payload, frame_in[DATA_W+1]}) != 1'(PARITY_ODD));
    end else begin : g_no_parity
      assign perr = 1'b0;
    end
  endgenerate

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) & out_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push = frame_valid & (~full | pop);
  assign drop = frame_valid & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (clr_err) begin
      overflow_d = 1'b0;
      err_cnt_d  = 16'h0000;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (frame_valid && (perr || ferr) && (err_cnt_q != 16'hFFFF))
        err_cnt_d = err_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {payload, perr, ferr};
  end

  logic [EW-1:0] head;
  assign head = mem_q[rd_ptr_q];

  assign out_valid  = (count_q != '0);
  assign data_out   = out_valid ? head[EW-1:2] : '0;
  assign parity_err = out_valid & head[1];
  assign frame_err  = out_valid & head[0];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_deframe_fifo.sv
// tb/tb_uart_deframe_fifo.sv - scoreboard bench for uart_deframe_fifo
// Stimulus pushes expected head entries; a negedge monitor compares them as the consumer pops.
module tb_uart_deframe_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] frame_in;
  logic        frame_valid;
  logic        clr_err;
  logic [7:0]  data_out;
  logic        parity_err;
  logic        frame_err;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [15:0] err_cnt;

  uart_deframe_fifo dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .clr_err(clr_err), .data_out(data_out), .parity_err(parity_err),
    .frame_err(frame_err), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Head entry {data, parity_err, frame_err} checked whenever the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", {data_out, parity_err, frame_err});
      end else begin
        chk("pop_entry", {22'd0, data_out, parity_err, frame_err}, {22'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [10:0] f, input logic [9:0] e, input bit store);
    frame_in    = f;
    frame_valid = 1'b1;
    if (store) sb.push_back(e);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] p);
    return {1'b1, ^p, p, 1'b0};
  endfunction

  initial begin
    rst = 1'b1; frame_in = '0; frame_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    push_frame(11'h54A, {8'hA5, 2'b00}, 1);
    chk("clean_valid", 32'(out_valid), 32'd1);
    chk("clean_data", 32'(data_out), 32'hA5);
    chk("clean_flags", 32'({parity_err, frame_err}), 32'd0);
    chk("clean_count", 32'(fifo_count), 32'd1);
    drain(1);
    chk("clean_drained_valid", 32'(out_valid), 32'd0);
    chk("clean_drained_count", 32'(fifo_count), 32'd0);

    push_frame(11'h74A, {8'hA5, 2'b10}, 1);
    chk("perr_head", 32'(parity_err), 32'd1);
    chk("perr_err_cnt", 32'(err_cnt), 32'd1);
    push_frame(11'h14A, {8'hA5, 2'b01}, 1);
    push_frame(11'h54B, {8'hA5, 2'b01}, 1);
    chk("ferr_err_cnt", 32'(err_cnt), 32'd3);
    chk("ferr_count", 32'(fifo_count), 32'd3);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_keeps_fifo", 32'(fifo_count), 32'd3);
    drain(3);
    chk("errs_drained", 32'(out_valid), 32'd0);
    chk("empty_data_zero", 32'({data_out, parity_err, frame_err}), 32'd0);

    for (int i = 0; i < 5; i++) push_frame(11'h478, {8'h3C, 2'b00}, i < 4);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_err_cnt", 32'(err_cnt), 32'd0);
    drain(4);
    chk("ovf_drained", 32'(out_valid), 32'd0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    for (int i = 1; i <= 4; i++) push_frame(mk_frame(8'(i * 8'h11)), {8'(i * 8'h11), 2'b00}, 1);
    chk("full_count", 32'(fifo_count), 32'd4);
    frame_in = mk_frame(8'h55); frame_valid = 1'b1; out_ready = 1'b1;
    sb.push_back({8'h55, 2'b00});
    tick();
    frame_valid = 1'b0; out_ready = 1'b0;
    chk("full_pushpop_count", 32'(fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    drain(4);
    chk("wrap_drained", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3; i++) push_frame(11'h74A, {8'hA5, 2'b10}, 1);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_err_cnt", 32'(err_cnt), 32'd3);
    rst = 1'b1; frame_in = 11'h74A; frame_valid = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0; frame_valid = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_outs", 32'({data_out, parity_err, frame_err, overflow}), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);

    for (int i = 0; i < 65537; i++) push_frame(11'h74A, {8'hA5, 2'b10}, i < 4);
    chk("sat_err_cnt", 32'(err_cnt), 32'hFFFF);
    chk("sat_overflow", 32'(overflow), 32'd1);
    chk("sat_count", 32'(fifo_count), 32'd4);
    drain(4);
    chk("sat_drained", 32'(out_valid), 32'd0);
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
